copro15_regfile: RTL and testbench

//  Parametrised CP15 register file for the Amber core: cache control, per-region

---
 rtl/copro15_regfile.sv | 207 ++++++++++++++++++++
 tb/tb_copro15_regfile.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/copro15_regfile.sv
// CP15 register file for the Amber core: cache control, region masks, fault capture and a handshaked flush FSM.
// Define AMBER_COPRO15_FAULT_FIFO_EN to queue faults in a FAULT_DEPTH-entry FIFO instead of a single last-wins record.
module copro15_regfile #(
  parameter int          NUM_REGIONS = 32,
  parameter int          FAULT_DEPTH = 4,
  parameter logic [31:0] ID_VALUE    = 32'h4156_0301
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_fetch_stall,
  input  logic [3:0]             i_copro_crn,
  input  logic [1:0]             i_copro_operation,
  input  logic [31:0]            i_copro_write_data,
  input  logic                   i_fault,
  input  logic [7:0]             i_fault_status,
  input  logic [31:0]            i_fault_address,
  input  logic                   i_cache_flush_done,
  output logic [31:0]            o_copro_read_data,
  output logic                   o_cache_enable,
  output logic                   o_cache_flush,
  output logic                   o_flush_busy,
  output logic [NUM_REGIONS-1:0] o_cacheable_area,
  output logic [NUM_REGIONS-1:0] o_updateable_area,
  output logic [NUM_REGIONS-1:0] o_disruptive_area
);

  localparam logic [1:0] OP_MCR = 2'd2;

  typedef enum logic {
    FLUSH_IDLE,
    FLUSH_REQ
  } flush_state_e;

  generate
    if (NUM_REGIONS < 1 || NUM_REGIONS > 32) begin : g_bad_regions
      $error("NUM_REGIONS must be in 1..32");
    end
    if (FAULT_DEPTH < 2 || (FAULT_DEPTH & (FAULT_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FAULT_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic                   mcr_active;
  logic                   fault_push;
  logic                   fault_pop_req;
  logic                   overflow_clr;
  logic [2:0]             cache_control_q;
  logic [NUM_REGIONS-1:0] cacheable_q;
  logic [NUM_REGIONS-1:0] updateable_q;
  logic [NUM_REGIONS-1:0] disruptive_q;
  logic [31:0]            read_data_q;
  logic [31:0]            read_data_d;
  logic [7:0]             head_status;
  logic [31:0]            head_address;
  logic [7:0]             fault_count;
  logic                   fault_overflow;
  flush_state_e           flush_state_q;
  flush_state_e           flush_state_d;

  assign mcr_active    = !i_fetch_stall && (i_copro_operation == OP_MCR);
  assign fault_push    = !i_fetch_stall && i_fault;
  assign fault_pop_req = mcr_active && (i_copro_crn == 4'd8) && i_copro_write_data[0];
  assign overflow_clr  = mcr_active && (i_copro_crn == 4'd8) && i_copro_write_data[1];

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cache_control_q <= '0;
      cacheable_q     <= '0;
      updateable_q    <= '0;
      disruptive_q    <= '0;
      read_data_q     <= '0;
    end else if (!i_fetch_stall) begin
      read_data_q <= read_data_d;
      if (mcr_active) begin
        case (i_copro_crn)
          4'd2:    cache_control_q <= i_copro_write_data[2:0];
          4'd3:    cacheable_q     <= i_copro_write_data[NUM_REGIONS-1:0];
          4'd4:    updateable_q    <= i_copro_write_data[NUM_REGIONS-1:0];
          4'd5:    disruptive_q    <= i_copro_write_data[NUM_REGIONS-1:0];
          default: ;
        endcase
      end
    end
  end

`ifdef AMBER_COPRO15_FAULT_FIFO_EN
  localparam int PTR_W = $clog2(FAULT_DEPTH);

  logic [7:0]       fifo_status_q [FAULT_DEPTH];
  logic [31:0]      fifo_address_q[FAULT_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             overflow_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             fifo_push;
  logic             fifo_drop;

  assign fifo_full  = (count_q == (PTR_W + 1)'(FAULT_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_pop   = fault_pop_req && !fifo_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign fifo_push  = fault_push && (!fifo_full || fifo_pop);
  assign fifo_drop  = fault_push && fifo_full && !fifo_pop;

  // NOTE: the storage array has no reset; entries are only visible once the count covers them.
  always_ff @(posedge i_clk) begin
    if (fifo_push) begin
      fifo_status_q[wr_ptr_q]  <= i_fault_status;
      fifo_address_q[wr_ptr_q] <= i_fault_address;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      if (fifo_drop)         overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  assign head_status    = fifo_empty ? 8'd0  : fifo_status_q[rd_ptr_q];
  assign head_address   = fifo_empty ? 32'd0 : fifo_address_q[rd_ptr_q];
  assign fault_count    = 8'(count_q);
  assign fault_overflow = overflow_q;
`else
  logic [7:0]  fault_status_q;
  logic [31:0] fault_address_q;
  logic        fault_valid_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fault_status_q  <= '0;
      fault_address_q <= '0;
      fault_valid_q   <= 1'b0;
    end else if (fault_push) begin
      fault_status_q  <= i_fault_status;
      fault_address_q <= i_fault_address;
      fault_valid_q   <= 1'b1;
    end else if (fault_pop_req) begin
      fault_valid_q   <= 1'b0;
    end
  end

  assign head_status    = fault_status_q;
  assign head_address   = fault_address_q;
  assign fault_count    = {7'd0, fault_valid_q};
  assign fault_overflow = 1'b0;
  // Overflow clear has nothing to act on in the single-record build.
  logic unused_overflow_clr;
  assign unused_overflow_clr = overflow_clr;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    read_data_d = '0;
    case (i_copro_crn)
      4'd0:    read_data_d = ID_VALUE;
      4'd2:    read_data_d[2:0] = cache_control_q;
      4'd3:    read_data_d[NUM_REGIONS-1:0] = cacheable_q;
      4'd4:    read_data_d[NUM_REGIONS-1:0] = updateable_q;
      4'd5:    read_data_d[NUM_REGIONS-1:0] = disruptive_q;
      4'd6:    read_data_d[7:0] = head_status;
      4'd7:    read_data_d = head_address;
      4'd8:    read_data_d = {fault_overflow, 23'd0, fault_count};
      default: read_data_d = '0;
    endcase
  end

  // The flush handshake ignores the fetch stall so the cache is never left waiting.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) flush_state_q <= FLUSH_IDLE;
    else          flush_state_q <= flush_state_d;
  end

  always_comb begin
    flush_state_d = flush_state_q;
    case (flush_state_q)
      FLUSH_IDLE: if (mcr_active && (i_copro_crn == 4'd1)) flush_state_d = FLUSH_REQ;
      FLUSH_REQ:  if (i_cache_flush_done)                  flush_state_d = FLUSH_IDLE;
      default:    flush_state_d = FLUSH_IDLE;
    endcase
  end

  assign o_copro_read_data = read_data_q;
  assign o_cache_enable    = cache_control_q[0];
  assign o_cache_flush     = (flush_state_q == FLUSH_REQ);
  assign o_flush_busy      = (flush_state_q == FLUSH_REQ);
  assign o_cacheable_area  = cacheable_q;
  assign o_updateable_area = updateable_q;
  assign o_disruptive_area = disruptive_q;

endmodule

// File: tb/tb_copro15_regfile.sv
// Directed self-checking bench for copro15_regfile with 8 regions and a 4-deep fault FIFO.
// Fault expectations follow AMBER_COPRO15_FAULT_FIFO_EN when it is defined, the single-record build otherwise.
module tb_copro15_regfile;

  localparam int NR = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_fetch_stall;
  logic [3:0]    i_copro_crn;
  logic [1:0]    i_copro_operation;
  logic [31:0]   i_copro_write_data;
  logic          i_fault;
  logic [7:0]    i_fault_status;
  logic [31:0]   i_fault_address;
  logic          i_cache_flush_done;
  logic [31:0]   o_copro_read_data;
  logic          o_cache_enable;
  logic          o_cache_flush;
  logic          o_flush_busy;
  logic [NR-1:0] o_cacheable_area;
  logic [NR-1:0] o_updateable_area;
  logic [NR-1:0] o_disruptive_area;

  int n_checks = 0;
  int n_pass   = 0;

  copro15_regfile #(
    .NUM_REGIONS(NR),
    .FAULT_DEPTH(4),
    .ID_VALUE   (32'h4156_0301)
  ) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_fetch_stall     (i_fetch_stall),
    .i_copro_crn       (i_copro_crn),
    .i_copro_operation (i_copro_operation),
    .i_copro_write_data(i_copro_write_data),
    .i_fault           (i_fault),
    .i_fault_status    (i_fault_status),
    .i_fault_address   (i_fault_address),
    .i_cache_flush_done(i_cache_flush_done),
    .o_copro_read_data (o_copro_read_data),
    .o_cache_enable    (o_cache_enable),
    .o_cache_flush     (o_cache_flush),
    .o_flush_busy      (o_flush_busy),
    .o_cacheable_area  (o_cacheable_area),
    .o_updateable_area (o_updateable_area),
    .o_disruptive_area (o_disruptive_area)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mcr(input logic [3:0] crn, input logic [31:0] data);
    i_copro_operation  = 2'd2;
    i_copro_crn        = crn;
    i_copro_write_data = data;
    tick();
    i_copro_operation  = 2'd0;
    i_copro_write_data = '0;
  endtask

  task automatic read_check(input logic [3:0] crn, input logic [31:0] exp, input string tag);
    i_copro_operation = 2'd1;
    i_copro_crn       = crn;
    tick();
    i_copro_operation = 2'd0;
    check(tag, o_copro_read_data, exp);
  endtask

  task automatic fault(input logic [7:0] st, input logic [31:0] addr);
    i_fault         = 1'b1;
    i_fault_status  = st;
    i_fault_address = addr;
    tick();
    i_fault         = 1'b0;
  endtask

  initial begin
    i_rst_n            = 1'b0;
    i_fetch_stall      = 1'b0;
    i_copro_crn        = '0;
    i_copro_operation  = '0;
    i_copro_write_data = '0;
    i_fault            = 1'b0;
    i_fault_status     = '0;
    i_fault_address    = '0;
    i_cache_flush_done = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_read_data", o_copro_read_data, 32'd0);
    check("rst_cache_en", 32'(o_cache_enable), 32'd0);
    check("rst_flush", 32'(o_cache_flush), 32'd0);
    check("rst_busy", 32'(o_flush_busy), 32'd0);
    check("rst_cacheable", 32'(o_cacheable_area), 32'd0);
    check("rst_updateable", 32'(o_updateable_area), 32'd0);
    check("rst_disruptive", 32'(o_disruptive_area), 32'd0);
    i_rst_n = 1'b1;
    read_check(4'd0, 32'h4156_0301, "rd_id");
    read_check(4'd3, 32'd0, "rd_crn3_rst");
    read_check(4'd8, 32'd0, "rd_crn8_rst");
    read_check(4'd12, 32'd0, "rd_unused_crn");

    // Mask writes truncate to NUM_REGIONS; a same-cycle read sees the old value
    mcr(4'd3, 32'hFFFF_FFFF);
    check("crn3_same_cycle_old", o_copro_read_data, 32'd0);
    check("cacheable_ff", 32'(o_cacheable_area), 32'h0000_00FF);
    read_check(4'd3, 32'h0000_00FF, "rd_crn3_ff");
    mcr(4'd4, 32'h1234_565A);
    mcr(4'd5, 32'hABCD_EFA5);
    check("updateable", 32'(o_updateable_area), 32'h0000_005A);
    check("disruptive", 32'(o_disruptive_area), 32'h0000_00A5);
    read_check(4'd5, 32'h0000_00A5, "rd_crn5");
    mcr(4'd2, 32'hFFFF_FFF7);
    check("cache_en_on", 32'(o_cache_enable), 32'd1);
    read_check(4'd2, 32'h0000_0007, "rd_crn2_7");
    mcr(4'd2, 32'hFFFF_FFF8);
    check("cache_en_off", 32'(o_cache_enable), 32'd0);
    read_check(4'd2, 32'd0, "rd_crn2_0");
    mcr(4'd2, 32'h0000_0001);

    // Flush handshake, merged second request, done ignored while idle
    mcr(4'd1, 32'd0);
    check("flush_req", 32'(o_cache_flush), 32'd1);
    check("flush_busy", 32'(o_flush_busy), 32'd1);
    mcr(4'd1, 32'd0);
    check("flush_merged", 32'(o_cache_flush), 32'd1);
    tick();
    tick();
    tick();
    check("flush_held", 32'(o_cache_flush), 32'd1);
    i_cache_flush_done = 1'b1;
    tick();
    i_cache_flush_done = 1'b0;
    check("flush_done_low", 32'(o_cache_flush), 32'd0);
    check("busy_done_low", 32'(o_flush_busy), 32'd0);
    i_cache_flush_done = 1'b1;
    tick();
    i_cache_flush_done = 1'b0;
    check("done_idle_ignored", 32'(o_flush_busy), 32'd0);
    i_fetch_stall = 1'b1;
    mcr(4'd1, 32'd0);
    check("stalled_flush_ignored", 32'(o_flush_busy), 32'd0);
    i_fetch_stall = 1'b0;
    mcr(4'd1, 32'd0);
    i_fetch_stall      = 1'b1;
    i_cache_flush_done = 1'b1;
    tick();
    i_cache_flush_done = 1'b0;
    i_fetch_stall      = 1'b0;
    check("done_while_stalled", 32'(o_cache_flush), 32'd0);

    // Fault capture
`ifdef AMBER_COPRO15_FAULT_FIFO_EN
    fault(8'h11, 32'h100);
    fault(8'h22, 32'h200);
    fault(8'h33, 32'h300);
    fault(8'h44, 32'h400);
    fault(8'h55, 32'h500);
    read_check(4'd8, 32'h8000_0004, "fifo_full_ovf");
    read_check(4'd7, 32'h0000_0100, "fifo_head_addr");
    read_check(4'd6, 32'h0000_0011, "fifo_head_status");
    mcr(4'd8, 32'h1);
    read_check(4'd7, 32'h0000_0200, "fifo_pop_addr");
    read_check(4'd8, 32'h8000_0003, "fifo_pop_count");
    mcr(4'd8, 32'h3);
    read_check(4'd8, 32'h0000_0002, "fifo_ovf_clear");
    fault(8'h66, 32'h600);
    fault(8'h77, 32'h700);
    i_fault            = 1'b1;
    i_fault_status     = 8'h88;
    i_fault_address    = 32'h800;
    mcr(4'd8, 32'h1);
    i_fault            = 1'b0;
    read_check(4'd8, 32'h0000_0004, "fifo_push_pop_full");
    read_check(4'd7, 32'h0000_0400, "fifo_head_after_pp");
    read_check(4'd6, 32'h0000_0044, "fifo_status_after_pp");
    for (int i = 0; i < 4; i++) mcr(4'd8, 32'h1);
    read_check(4'd8, 32'd0, "fifo_drained");
    read_check(4'd7, 32'd0, "fifo_empty_addr");
    mcr(4'd8, 32'h1);
    read_check(4'd8, 32'd0, "fifo_pop_empty");
    fault(8'h99, 32'h900);
    read_check(4'd7, 32'h0000_0900, "fifo_after_wrap");
    read_check(4'd8, 32'h0000_0001, "fifo_count_one");
    mcr(4'd8, 32'h1);
`else
    fault(8'h11, 32'h100);
    fault(8'h22, 32'h200);
    read_check(4'd7, 32'h0000_0200, "single_last_addr");
    read_check(4'd6, 32'h0000_0022, "single_last_status");
    read_check(4'd8, 32'h0000_0001, "single_count");
    mcr(4'd8, 32'h3);
    read_check(4'd8, 32'd0, "single_pop");
`endif

    // Stall freezes register writes, fault capture and read data
    read_check(4'd0, 32'h4156_0301, "rd_id_pre_stall");
    i_fetch_stall      = 1'b1;
    i_fault            = 1'b1;
    i_fault_status     = 8'hEE;
    i_fault_address    = 32'hDEAD_0000;
    mcr(4'd2, 32'h0);
    i_fault            = 1'b0;
    check("stall_read_frozen", o_copro_read_data, 32'h4156_0301);
    check("stall_cache_en", 32'(o_cache_enable), 32'd1);
    i_fetch_stall = 1'b0;
    read_check(4'd2, 32'h0000_0001, "stall_crn2_kept");
    read_check(4'd8, 32'd0, "stall_no_fault");

    // Reset while a flush is outstanding
    mcr(4'd1, 32'd0);
    check("pre_reset_busy", 32'(o_flush_busy), 32'd1);
    i_rst_n = 1'b0;
    tick();
    check("reset_flush", 32'(o_cache_flush), 32'd0);
    check("reset_busy", 32'(o_flush_busy), 32'd0);
    check("reset_cacheable", 32'(o_cacheable_area), 32'd0);
    check("reset_cache_en", 32'(o_cache_enable), 32'd0);
    check("reset_read_data", o_copro_read_data, 32'd0);
    i_rst_n = 1'b1;
    tick();
    check("post_reset_idle", 32'(o_flush_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
